threat_range_eval: RTL and testbench

- Stage directly downstream of the coordinate parser.
- Consumes Gray-coded 16-bit X/Y/Z target coordinates over a valid/ready handshake and converts them to binary.
- Computes the squared horizontal range to the defended asset and classifies the target into a threat level for the engagement controller.
- Multi-cycle, one target in flight; uses a single shared 17x17 multiplier.

---
 rtl/threat_range_eval.sv | 198 +++++++++++++++++++
 tb/tb_threat_range_eval.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/threat_range_eval.sv
// threat_range_eval
// Gray-to-binary coordinate decode, squared horizontal range to the defended
// asset and threat classification. One target in flight at a time; a single
// 17x17 multiplier is shared between the dx^2 and dy^2 steps.
// Optional build macro: ENGAGE_CNT_EN adds a saturating engage_count output.
module threat_range_eval #(
    parameter logic [15:0] CENTER_X = 16'd32768,
    parameter logic [15:0] CENTER_Y = 16'd32768,
    parameter logic [15:0] TRACK_R  = 16'd8000,
    parameter logic [15:0] ENGAGE_R = 16'd2000,
    parameter logic [15:0] ALT_MAX  = 16'd20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x_gray,
    input  logic [15:0] y_gray,
    input  logic [15:0] z_gray,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] range_sq,
    output logic [15:0] alt_bin,
    output logic [1:0]  threat_level,
    output logic        out_valid,
    input  logic        out_ready
`ifdef ENGAGE_CNT_EN
    ,
    output logic [15:0] engage_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SQX   = 3'd1;
    localparam logic [2:0] S_SQY   = 3'd2;
    localparam logic [2:0] S_CLASS = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    // Zone thresholds squared once at elaboration; widened to the accumulator.
    localparam logic [31:0] ENGAGE_SQ = {16'd0, ENGAGE_R} * {16'd0, ENGAGE_R};
    localparam logic [31:0] TRACK_SQ  = {16'd0, TRACK_R} * {16'd0, TRACK_R};

    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [15:0] dx_q, dx_d;
    logic [15:0] dy_q, dy_d;
    logic [15:0] z_q, z_d;
    logic [32:0] acc_q, acc_d;
    logic [32:0] range_q, range_d;
    logic [15:0] alt_q, alt_d;
    logic [1:0]  tl_q, tl_d;
    logic        ov_q, ov_d;

    logic [15:0] x_bin, y_bin, z_bin;
    logic [15:0] dx_in, dy_in;
    logic [16:0] mul_op;
    logic [32:0] prod;
    logic [1:0]  class_lvl;
    logic        accept;
    logic        xfer;

    // Combinational decode and absolute distance from the asset on each axis.
    always_comb begin
        x_bin = gray2bin(x_gray);
        y_bin = gray2bin(y_gray);
        z_bin = gray2bin(z_gray);
        dx_in = (x_bin >= CENTER_X) ? (x_bin - CENTER_X) : (CENTER_X - x_bin);
        dy_in = (y_bin >= CENTER_Y) ? (y_bin - CENTER_Y) : (CENTER_Y - y_bin);
    end

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign xfer     = ov_q & out_ready;

    // Shared squarer: dx in SQX, dy otherwise. Max 32768^2 = 2^30 fits easily.
    always_comb begin
        mul_op = (state_q == S_SQX) ? {1'b0, dx_q} : {1'b0, dy_q};
        prod   = 33'(mul_op) * 33'(mul_op);
    end

    // Classification of the finished accumulator; altitude gate dominates.
    always_comb begin
        if (z_q > ALT_MAX)
            class_lvl = 2'd0;
        else if (acc_q <= {1'b0, ENGAGE_SQ})
            class_lvl = 2'd3;
        else if (acc_q <= {1'b0, TRACK_SQ})
            class_lvl = 2'd2;
        else
            class_lvl = 2'd1;
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        z_d     = z_q;
        acc_d   = acc_q;
        range_d = range_q;
        alt_d   = alt_q;
        tl_d    = tl_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dx_d    = dx_in;
                    dy_d    = dy_in;
                    z_d     = z_bin;
                    state_d = S_SQX;
                end
            end
            S_SQX: begin
                acc_d   = prod;
                state_d = S_SQY;
            end
            S_SQY: begin
                acc_d   = acc_q + prod;
                state_d = S_CLASS;
            end
            S_CLASS: begin
                range_d = acc_q;
                alt_d   = z_q;
                tl_d    = class_lvl;
                ov_d    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (xfer) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ov_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; async reset abandons any in-flight target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dx_q    <= '0;
            dy_q    <= '0;
            z_q     <= '0;
            acc_q   <= '0;
            range_q <= '0;
            alt_q   <= '0;
            tl_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            z_q     <= z_d;
            acc_q   <= acc_d;
            range_q <= range_d;
            alt_q   <= alt_d;
            tl_q    <= tl_d;
            ov_q    <= ov_d;
        end
    end

    assign range_sq     = range_q;
    assign alt_bin      = alt_q;
    assign threat_level = tl_q;
    assign out_valid    = ov_q;

`ifdef ENGAGE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count delivered engage results, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer && (tl_q == 2'd3) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    // Engage counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign engage_count = cnt_q;
`endif

endmodule

// File: tb/tb_threat_range_eval.sv
// Bench for threat_range_eval: directed targets with literal expectations,
// plus a per-cycle comparison of the output against a reference model.
module tb_threat_range_eval;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] x_gray, y_gray, z_gray;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] range_sq;
    logic [15:0] alt_bin;
    logic [1:0]  threat_level;
    logic        out_valid;
    logic        out_ready;
`ifdef ENGAGE_CNT_EN
    logic [15:0] engage_count;
`endif

    threat_range_eval dut (
        .clk(clk),
        .reset_n(reset_n),
        .x_gray(x_gray),
        .y_gray(y_gray),
        .z_gray(z_gray),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .range_sq(range_sq),
        .alt_bin(alt_bin),
        .threat_level(threat_level),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef ENGAGE_CNT_EN
        ,
        .engage_count(engage_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] r;
        logic [15:0] a;
        logic [1:0]  t;
    } res_t;

    res_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // Gray decode by prefix-xor doubling.
    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        return b;
    endfunction

    function automatic res_t model(input logic [15:0] xg, input logic [15:0] yg, input logic [15:0] zg);
        res_t   m;
        longint dx, dy, r;
        dx = longint'(g2b(xg)) - 32768;
        dy = longint'(g2b(yg)) - 32768;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        r = dx * dx + dy * dy;
        m.r = 33'(r);
        m.a = g2b(zg);
        if (m.a > 16'd20000)        m.t = 2'd0;
        else if (r <= 2000 * 2000)  m.t = 2'd3;
        else if (r <= 8000 * 8000)  m.t = 2'd2;
        else                        m.t = 2'd1;
        return m;
    endfunction

    // Every valid cycle the output must equal the oldest outstanding result.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_cnt = 0;
        end else begin
`ifdef ENGAGE_CNT_EN
            chk("engage_count", 64'(engage_count), 64'(exp_cnt));
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("cmp_range_sq", 64'(range_sq), 64'(exp_q[0].r));
                    chk("cmp_alt_bin", 64'(alt_bin), 64'(exp_q[0].a));
                    chk("cmp_threat", 64'(threat_level), 64'(exp_q[0].t));
                    if (out_ready) begin
                        if (exp_q[0].t == 2'd3 && exp_cnt != 16'hFFFF) exp_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_gray   = x;
        y_gray   = y;
        z_gray   = z;
        in_valid = 1'b1;
    endtask

    // One target with out_ready held high; entered and left at posedge+1.
    task automatic run_target(input string tag, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] z, input logic [32:0] r,
                              input logic [15:0] a, input logic [1:0] t);
        res_t m;
        m = model(x, y, z);
        chk({tag, "_model_r"}, 64'(m.r), 64'(r));
        chk({tag, "_model_t"}, 64'(m.t), 64'(t));
        exp_q.push_back(m);
        drive(x, y, z);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_lat_out_valid"}, 64'(out_valid), 64'd0);
            chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_range_sq"}, 64'(range_sq), 64'(r));
        chk({tag, "_alt_bin"}, 64'(alt_bin), 64'(a));
        chk({tag, "_threat"}, 64'(threat_level), 64'(t));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        x_gray    = '0;
        y_gray    = '0;
        z_gray    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_range_sq", 64'(range_sq), 64'd0);
        chk("rst_alt_bin", 64'(alt_bin), 64'd0);
        chk("rst_threat", 64'(threat_level), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Backpressure: engage result held while a second target waits upstream.
        exp_q.push_back(model(16'hC21C, 16'hC000, 16'h021C));
        exp_q.push_back(model(16'hC000, 16'hDA4C, 16'h021C));
        drive(16'hC21C, 16'hC000, 16'h021C);
        @(posedge clk);
        #1 drive(16'hC000, 16'hDA4C, 16'h021C);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_range_sq", 64'(range_sq), 64'd1000000);
            chk("bp_threat", 64'(threat_level), 64'd3);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
`ifdef ENGAGE_CNT_EN
        chk("bp_engage_count", 64'(engage_count), 64'd1);
`endif
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp2_out_valid", 64'(out_valid), 64'd1);
        chk("bp2_range_sq", 64'(range_sq), 64'd25000000);
        chk("bp2_alt_bin", 64'(alt_bin), 64'd1000);
        chk("bp2_threat", 64'(threat_level), 64'd2);
        @(posedge clk);
        @(negedge clk);
        chk("bp2_post_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        run_target("track", 16'hC000, 16'hDA4C, 16'h021C, 33'd25000000, 16'd1000, 2'd2);
        run_target("monitor", 16'h0000, 16'h0000, 16'h0000, 33'd2147483648, 16'd0, 2'd1);
        run_target("alt_gate", 16'hC000, 16'hC000, 16'h4FA8, 33'd0, 16'd30000, 2'd0);
        run_target("engage", 16'hC21C, 16'hC000, 16'h021C, 33'd1000000, 16'd1000, 2'd3);

        // Reset while in SQY: no result may ever appear for this target.
        drive(16'hC21C, 16'hC000, 16'h021C);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_threat", 64'(threat_level), 64'd0);
        chk("midrst_range_sq", 64'(range_sq), 64'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_result", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        run_target("recover", 16'hC21C, 16'hC000, 16'h021C, 33'd1000000, 16'd1000, 2'd3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
